// File: rtl/chunked_add_sub_acc_pkg.sv
// chunked_add_sub_acc_pkg
//   Shared encodings for the chunked adder/subtractor/accumulator: the op
//   codes driven on the op port and the controller state type. Imported by
//   the RTL and by the testbench so both sides agree on the encodings.
package chunked_add_sub_acc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : chunked_add_sub_acc_pkg

// File: rtl/chunked_add_sub_acc_adder.sv
// chunked_add_sub_acc_adder
//   Plain full-adder ripple chain of width N. Used by the top level as the
//   K-bit slice that processes one chunk per clock.
// Ports:
//   a_i, b_i  in  N  addends
//   ci_i      in  1  carry-in to bit 0
//   sum_o     out N  a_i + b_i + ci_i (modulo 2^N)
//   co_o      out 1  carry out of bit N-1
module chunked_add_sub_acc_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         ci_i,
  output logic [N-1:0] sum_o,
  output logic         co_o
);

  logic [N:0] carry;

  assign carry[0] = ci_i;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign co_o = carry[N];

endmodule : chunked_add_sub_acc_adder

// File: rtl/chunked_add_sub_acc.sv
// chunked_add_sub_acc
//   Multi-cycle N-bit add / subtract / accumulate / clear unit that pushes
//   the operation through a single K-bit ripple slice, one chunk per clock,
//   least-significant chunk first. A start/busy/done handshake frames each
//   operation; sum/co/ovf only change on completion.
// Ports:
//   clk    in  1  clock, rising edge
//   rst_n  in  1  asynchronous reset, active-low
//   start  in  1  operation request, sampled only while idle
//   op     in  2  00 add, 01 subtract, 10 accumulate, 11 clear accumulator
//   a      in  N  operand A (sampled with start)
//   b      in  N  operand B (sampled with start; unused for acc/clear)
//   ci     in  1  carry-in for add (sampled with start)
//   busy   out 1  operation in flight (state not IDLE)
//   done   out 1  one-cycle pulse when sum/co/ovf update
//   sum    out N  last completed result
//   co     out 1  carry out of the MSB (subtract: 1 = no borrow)
//   ovf    out 1  two's-complement overflow of the last result
module chunked_add_sub_acc
  import chunked_add_sub_acc_pkg::*;
#(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         co,
  output logic         ovf
);

  localparam int CHUNKS = N / K;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);

  // Controller
  state_e state_q, state_d;

  // Operation registers, loaded when a start is accepted
  logic [N-1:0]     opa_q, opb_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             acc_upd_q;   // acc/clear write their result back to acc
  logic [N-1:0]     res_q;

  // Architectural state
  logic [N-1:0]     acc_q;
  logic [N-1:0]     sum_q;
  logic             co_q;
  logic             ovf_q;

  // Combinational helpers
  logic             accept;
  logic             last_chunk;
  logic [N-1:0]     opa_sel, opb_sel;
  logic             c0_sel;
  logic [K-1:0]     slice_a, slice_b, slice_sum;
  logic             slice_co;
  logic [N-1:0]     res_d;
  logic             ovf_d;

  assign accept     = (state_q == ST_IDLE) && start;
  assign last_chunk = (cnt_q == LAST_CHUNK);

  // ---------------------------------------------------------------------
  // FSM: state register + next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every sequential process uses non-blocking (<=) so all registers
  // update together from pre-edge values; combinational processes use '='.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets its default before the case so no path through this
  // process leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)      state_d = ST_RUN;
      ST_RUN:  if (last_chunk) state_d = ST_DONE;
      ST_DONE:                 state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Operand selection at start: subtract is a + ~b + 1, accumulate adds the
  // new operand to the stored accumulator, clear adds zero to zero so it
  // runs through the same completion path as every other op.
  // ---------------------------------------------------------------------
  always_comb begin
    opa_sel = '0;
    opb_sel = '0;
    c0_sel  = 1'b0;
    case (op)
      OP_ADD: begin
        opa_sel = a;
        opb_sel = b;
        c0_sel  = ci;
      end
      OP_SUB: begin
        opa_sel = a;
        opb_sel = ~b;
        c0_sel  = 1'b1;
      end
      OP_ACC: begin
        opa_sel = acc_q;
        opb_sel = a;
      end
      default: begin
        opa_sel = '0;
        opb_sel = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Slice datapath: one K-bit chunk per RUN cycle
  // ---------------------------------------------------------------------
  assign slice_a = opa_q[cnt_q*K +: K];
  assign slice_b = opb_q[cnt_q*K +: K];

  chunked_add_sub_acc_adder #(
    .N (K)
  ) u_slice (
    .a_i   (slice_a),
    .b_i   (slice_b),
    .ci_i  (carry_q),
    .sum_o (slice_sum),
    .co_o  (slice_co)
  );

  // res_d is the result register with the current chunk merged in; on the
  // last chunk it is the complete result, so completion reads it directly.
  always_comb begin
    res_d = res_q;
    res_d[cnt_q*K +: K] = slice_sum;
  end

  assign ovf_d = (opa_q[N-1] == opb_q[N-1]) && (res_d[N-1] != opa_q[N-1]);

  // NOTE: every register here, including the accumulator and the operand
  // copies, is cleared by rst_n so a reset mid-operation leaves no stale
  // state behind and the accumulator restarts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q     <= '0;
      opb_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      acc_upd_q <= 1'b0;
      res_q     <= '0;
      acc_q     <= '0;
      sum_q     <= '0;
      co_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (accept) begin
      opa_q     <= opa_sel;
      opb_q     <= opb_sel;
      carry_q   <= c0_sel;
      cnt_q     <= '0;
      acc_upd_q <= op[1];
    end else if (state_q == ST_RUN) begin
      res_q   <= res_d;
      carry_q <= slice_co;
      if (last_chunk) begin
        cnt_q <= '0;
        sum_q <= res_d;
        co_q  <= slice_co;
        ovf_q <= ovf_d;
        if (acc_upd_q) begin
          acc_q <= res_d;
        end
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule : chunked_add_sub_acc

// File: tb/tb_chunked_add_sub_acc.sv
// tb_chunked_add_sub_acc
//   Self-checking bench: four instances (K = 4, 1, 8, 16) with N = 16 share
//   operand inputs and reset but have private start lines. Expected results
//   are queued when a start is driven and compared by a monitor when done
//   pulses, including the start-to-done latency.
module tb_chunked_add_sub_acc;
  import chunked_add_sub_acc_pkg::*;

  localparam int N    = 16;
  localparam int NDUT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         start_v [NDUT];
  logic [1:0]   op;
  logic [N-1:0] a, b;
  logic         ci;
  logic         busy_v  [NDUT];
  logic         done_v  [NDUT];
  logic [N-1:0] sum_v   [NDUT];
  logic         co_v    [NDUT];
  logic         ovf_v   [NDUT];

  function automatic int kval(input int g);
    case (g)
      0:       return 4;
      1:       return 1;
      2:       return 8;
      default: return 16;
    endcase
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    chunked_add_sub_acc #(
      .N (N),
      .K ((g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 8 : 16)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_v[g]),
      .op    (op),
      .a     (a),
      .b     (b),
      .ci    (ci),
      .busy  (busy_v[g]),
      .done  (done_v[g]),
      .sum   (sum_v[g]),
      .co    (co_v[g]),
      .ovf   (ovf_v[g])
    );
  end

  // ---------------------------------------------------------------------
  // Checking infrastructure
  // ---------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_dones  = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    int           idx;
    logic [N-1:0] sum;
    logic         co;
    logic         ovf;
    int           start_cyc;
    int           lat;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ci;
    logic [N-1:0] sum;
    logic         co;
    logic         ovf;
  } vec_t;

  // Monitor: every done pulse pops one expectation
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int g = 0; g < NDUT; g++) begin
          if (done_v[g]) begin
            n_dones++;
            if (sb.size() == 0) begin
              check($sformatf("dut%0d_unexpected_done", g), 1, 0);
            end else begin
              e = sb.pop_front();
              check($sformatf("dut%0d_done_owner", g), g, e.idx);
              check($sformatf("dut%0d_sum", g), sum_v[g], e.sum);
              check($sformatf("dut%0d_co", g), co_v[g], e.co);
              check($sformatf("dut%0d_ovf", g), ovf_v[g], e.ovf);
              check($sformatf("dut%0d_latency", g), cyc - e.start_cyc, e.lat);
              check($sformatf("dut%0d_busy_at_done", g), busy_v[g], 1);
            end
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push an expectation, pulse start for one edge, wait (bounded) for the
  // monitor to consume it, then confirm done/busy dropped one cycle later.
  task automatic do_op(input int g, input logic [1:0] o, input logic [N-1:0] va,
                       input logic [N-1:0] vb, input logic vci,
                       input logic [N-1:0] esum, input logic eco, input logic eovf);
    exp_t e;
    e.idx = g; e.sum = esum; e.co = eco; e.ovf = eovf;
    e.start_cyc = cyc + 1;
    e.lat = N / kval(g);
    sb.push_back(e);
    op = o; a = va; b = vb; ci = vci;
    start_v[g] = 1'b1;
    tick();
    start_v[g] = 1'b0;
    op = 2'($urandom); a = N'($urandom); b = N'($urandom); ci = 1'($urandom);
    check($sformatf("dut%0d_busy_after_start", g), busy_v[g], 1);
    for (int n = 0; n < 40 && sb.size() != 0; n++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      check($sformatf("dut%0d_done_timeout", g), 1, 0);
      sb.delete();
    end
    tick();
    check($sformatf("dut%0d_done_cleared", g), done_v[g], 0);
    check($sformatf("dut%0d_idle_after_done", g), busy_v[g], 0);
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  vec_t vecs[14];
  int   dones_before;

  initial begin
    vecs[0]  = '{OP_ADD, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
    vecs[1]  = '{OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{OP_ADD, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[3]  = '{OP_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[4]  = '{OP_SUB, 16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[5]  = '{OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[6]  = '{OP_SUB, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[7]  = '{OP_CLR, 16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{OP_ACC, 16'h7FFF, 16'h1234, 1'b1, 16'h7FFF, 1'b0, 1'b0};
    vecs[9]  = '{OP_ACC, 16'h0001, 16'hFFFF, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[10] = '{OP_ACC, 16'h0000, 16'h0F0F, 1'b0, 16'h8000, 1'b0, 1'b0};
    vecs[11] = '{OP_ACC, 16'hFFFF, 16'h0000, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[12] = '{OP_CLR, 16'h1111, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[13] = '{OP_ACC, 16'h0005, 16'h9999, 1'b1, 16'h0005, 1'b0, 1'b0};

    rst_n = 1'b0;
    for (int g = 0; g < NDUT; g++) start_v[g] = 1'b0;
    op = OP_ADD; a = '0; b = '0; ci = 1'b0;

    fork
      monitor();
    join_none

    // Reset state
    tick();
    tick();
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("dut%0d_rst_busy", g), busy_v[g], 0);
      check($sformatf("dut%0d_rst_done", g), done_v[g], 0);
      check($sformatf("dut%0d_rst_sum", g), sum_v[g], 0);
      check($sformatf("dut%0d_rst_co", g), co_v[g], 0);
      check($sformatf("dut%0d_rst_ovf", g), ovf_v[g], 0);
    end
    rst_n = 1'b1;
    tick();

    // Table-driven operations on the K=4 instance
    for (int i = 0; i < 14; i++) begin
      do_op(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci,
            vecs[i].sum, vecs[i].co, vecs[i].ovf);
    end

    // sum/co/ovf hold between completions
    repeat (3) tick();
    check("hold_sum", sum_v[0], 16'h0005);

    // start held high across two full operations: only the starts seen in
    // IDLE (edges 0 and N/K+2) are taken, with the operands present then.
    dones_before = n_dones;
    for (int i = 0; i < 12; i++) begin
      op = OP_ADD;
      a  = N'(16'h0100 * i + 1);
      b  = N'(i);
      ci = 1'b0;
      if (i == 0) sb.push_back('{0, 16'h0001, 1'b0, 1'b0, cyc + 1, 4});
      if (i == 6) sb.push_back('{0, 16'h0607, 1'b0, 1'b0, cyc + 1, 4});
      start_v[0] = 1'b1;
      tick();
    end
    start_v[0] = 1'b0;
    repeat (8) tick();
    check("b2b_queue_drained", sb.size(), 0);
    check("b2b_done_count", n_dones - dones_before, 2);
    sb.delete();

    // Reset in the middle of RUN: outputs and accumulator return to zero
    op = OP_ADD; a = 16'h1234; b = 16'h0FCD; ci = 1'b0;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    tick();
    check("mid_busy_before_rst", busy_v[0], 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy_v[0], 0);
    check("mid_rst_done", done_v[0], 0);
    check("mid_rst_sum", sum_v[0], 0);
    check("mid_rst_co", co_v[0], 0);
    check("mid_rst_ovf", ovf_v[0], 0);
    dones_before = n_dones;
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    check("mid_rst_no_done", n_dones - dones_before, 0);
    do_op(0, OP_ACC, 16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0);

    // Same add on K=1, K=8 and K=N instances (latency 16, 2, 1)
    for (int g = 1; g < NDUT; g++) begin
      do_op(g, OP_ADD, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
      do_op(g, OP_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    end

    repeat (2) tick();
    check("final_queue_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_chunked_add_sub_acc
